// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port plus the IF/ID valid/ready output register.
interface instr_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_data, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_data, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads asynchronous instruction memory and
// fills the IF/ID register; handles redirect flushes, the halt word and start/restart.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(16'hFF00)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_if.master     bus,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              adv;
  logic              accept;

  assign bus.imem_addr = pc;
  assign bus.out_valid = valid;
  assign bus.out_instr = instr;
  assign bus.out_pc    = instr_pc;

  assign adv    = (state == RUN) && (!valid || bus.out_ready);
  assign accept = valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      valid       <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      // The handshake is counted even when a redirect flushes the register this cycle.
      if (accept && (fetch_count != '1))
        fetch_count <= fetch_count + 16'd1;

      if (redirect) begin
        pc     <= redirect_pc;
        valid  <= 1'b0;
        state  <= RUN;
        halted <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start)
              state <= RUN;
          end
          RUN: begin
            if (adv) begin
              instr    <= bus.imem_data;
              instr_pc <= pc;
              valid    <= 1'b1;
              pc       <= pc + ADDR_W'(1);
              // The halt word itself still goes downstream; fetching stops after it.
              if (bus.imem_data == HALT_WORD) begin
                state  <= HALTED;
                halted <= 1'b1;
              end
            end
          end
          HALTED: begin
            if (accept)
              valid <= 1'b0;
            if (start) begin
              state  <= RUN;
              halted <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboard of expected (pc, instr) pairs
// consumed on every downstream handshake, plus directed checks at each step.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;
  logic [15:0]       fetch_count;

  logic [DATA_W-1:0] mem [1024];
  exp_t              q[$];
  logic [15:0]       exp_count;
  int unsigned       vectors;
  int unsigned       miscompares;

  instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (10'd0),
    .HALT_WORD(16'hFF00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bus        (ifc),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  assign ifc.imem_data = mem[ifc.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int unsigned from, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      logic [ADDR_W-1:0] p;
      p = ADDR_W'((from + k) % 1024);
      q.push_back('{pc: p, instr: mem[p]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs until out_pc == p is presented, then stalls the output there.
  task automatic wait_pc(input int unsigned p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      if (ifc.out_valid && (ifc.out_pc == ADDR_W'(p))) begin
        ifc.out_ready = 1'b0;
        seen = 1'b1;
      end
    end
    check("wait_pc", 32'(seen), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_count = '0;
    end else begin
      check("fetch_count", 32'(fetch_count), 32'(exp_count));
      if (ifc.out_valid && ifc.out_ready) begin
        check("sb_avail", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("out_pc", 32'(ifc.out_pc), 32'(e.pc));
          check("out_instr", 32'(ifc.out_instr), 32'(e.instr));
        end
        if (exp_count != 16'hFFFF)
          exp_count = exp_count + 16'd1;
      end
    end
  end

  initial begin
    bit seen;
    vectors     = 0;
    miscompares = 0;
    exp_count   = '0;
    for (int unsigned i = 0; i < 1024; i++)
      mem[i] = 16'(i * 5 + 16'h0A00);
    mem[83] = 16'hFF00;

    rst_n         = 1'b0;
    start         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    ifc.out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_instr", 32'(ifc.out_instr), 32'd0);
    check("rst_out_pc", 32'(ifc.out_pc), 32'd0);
    check("rst_imem_addr", 32'(ifc.imem_addr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
    step();
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("idle_no_fetch", 32'(ifc.out_valid), 32'd0);
    check("idle_addr", 32'(ifc.imem_addr), 32'd0);

    // T1: stream from 0; T2: stall on pc 4
    push_range(0, 7);
    pulse_start();
    wait_pc(4);
    check("t1_count4", 32'(fetch_count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_valid", 32'(ifc.out_valid), 32'd1);
      check("t2_pc", 32'(ifc.out_pc), 32'd4);
      check("t2_instr", 32'(ifc.out_instr), 32'(mem[4]));
      check("t2_addr", 32'(ifc.imem_addr), 32'd5);
    end
    ifc.out_ready = 1'b1;
    wait_pc(7);

    // T3: redirect while pc 7 is valid and stalled
    redirect    = 1'b1;
    redirect_pc = 10'd40;
    step();
    redirect = 1'b0;
    check("t3_flush", 32'(ifc.out_valid), 32'd0);
    check("t3_addr", 32'(ifc.imem_addr), 32'd40);
    check("t3_count", 32'(fetch_count), 32'd7);
    push_range(40, 4);
    step();
    check("t3_valid", 32'(ifc.out_valid), 32'd1);
    check("t3_pc", 32'(ifc.out_pc), 32'd40);
    check("t3_instr", 32'(ifc.out_instr), 32'(mem[40]));
    ifc.out_ready = 1'b1;
    wait_pc(44);

    // T4: halt word at 83
    redirect    = 1'b1;
    redirect_pc = 10'd80;
    step();
    redirect = 1'b0;
    push_range(80, 4);
    ifc.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (halted) seen = 1'b1;
    end
    check("t4_halt_seen", 32'(seen), 32'd1);
    check("t4_valid", 32'(ifc.out_valid), 32'd1);
    check("t4_pc", 32'(ifc.out_pc), 32'd83);
    check("t4_instr", 32'(ifc.out_instr), 32'hFF00);
    check("t4_addr", 32'(ifc.imem_addr), 32'd84);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_idle_valid", 32'(ifc.out_valid), 32'd0);
      check("t4_hold_addr", 32'(ifc.imem_addr), 32'd84);
      check("t4_halted", 32'(halted), 32'd1);
    end
    push_range(84, 3);
    pulse_start();
    check("t4_resume", 32'(halted), 32'd0);
    wait_pc(87);

    // T5: redirect with a same-cycle handshake, then wrap
    push_range(87, 1);
    ifc.out_ready = 1'b1;
    redirect      = 1'b1;
    redirect_pc   = 10'd1022;
    step();
    redirect = 1'b0;
    check("t5_flush", 32'(ifc.out_valid), 32'd0);
    push_range(1022, 4);
    wait_pc(2);

    // T6: asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(ifc.out_valid), 32'd0);
    check("t6_addr", 32'(ifc.imem_addr), 32'd0);
    check("t6_count", 32'(fetch_count), 32'd0);
    check("t6_pc", 32'(ifc.out_pc), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_idle", 32'(ifc.out_valid), 32'd0);
    ifc.out_ready = 1'b1;
    push_range(0, 2);
    pulse_start();
    wait_pc(2);
    check("sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
